// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package inst_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int          EXP_ADEL_DEFAULT = 13;
    localparam int          EXP_W            = 14;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_CANCEL,
        S_EXC
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]      inst1;
        logic [31:0]      inst2;
        logic [31:0]      pc;
        logic [EXP_W-1:0] exp;
        logic             two_valid;
    } resp_t;

endpackage

// File: rtl/inst_fetch_unit_resp_buf.sv
// rtl/inst_fetch_unit_resp_buf.sv - one-entry holding register for a fetch response
module inst_fetch_unit_resp_buf
    import inst_fetch_unit_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  load,
    input  logic  clear,
    input  resp_t load_data,
    output resp_t data,
    output logic  valid
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (clear) begin
            data  <= '0;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch PC generation, icache request FSM and FIFO write mux
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          EXP_ADEL = EXP_ADEL_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             fifo_full,
    output logic             inst_req,
    output logic [31:0]      inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [63:0]      inst_rdata,
    output logic             write_en_1,
    output logic             write_en_2,
    output logic [31:0]      write_inst1,
    output logic [31:0]      write_inst2,
    output logic [31:0]      write_pc1,
    output logic [31:0]      write_pc2,
    output logic [EXP_W-1:0] write_inst_exp1
);

    fetch_state_t state, next_state;
    logic [31:0]  pc_q, pc_d;
    logic         req, wr1, wr2;
    logic         buf_load, buf_clear, buf_valid;
    resp_t        buf_in, hold_q;
    logic         misaligned, hold_out;

    assign misaligned = (pc_q[1:0] != 2'b00);

    inst_fetch_unit_resp_buf u_resp_buf (
        .clk       (clk),
        .resetn    (resetn),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_data (buf_in),
        .data      (hold_q),
        .valid     (buf_valid)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_REQ;
            pc_q  <= RESET_PC;
        end else begin
            state <= next_state;
            pc_q  <= pc_d;
        end
    end

    always_comb begin
        next_state = state;
        pc_d       = pc_q;
        req        = 1'b0;
        wr1        = 1'b0;
        wr2        = 1'b0;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        buf_in     = '0;
        case (state)
            S_REQ: begin
                req = !misaligned && !buf_valid;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (req && inst_addr_ok) next_state = S_CANCEL;
                end else if (misaligned) begin
                    // Address error becomes a single zero-instruction entry flagged in exp
                    buf_in.pc            = pc_q;
                    buf_in.exp[EXP_ADEL] = 1'b1;
                    buf_load             = 1'b1;
                    next_state           = S_HOLD;
                end else if (req && inst_addr_ok) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    next_state = inst_data_ok ? S_REQ : S_CANCEL;
                end else if (inst_data_ok) begin
                    buf_in.inst1     = pc_q[2] ? inst_rdata[63:32] : inst_rdata[31:0];
                    buf_in.inst2     = inst_rdata[63:32];
                    buf_in.pc        = pc_q;
                    buf_in.two_valid = !pc_q[2];
                    buf_load         = 1'b1;
                    next_state       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    buf_clear  = 1'b1;
                    next_state = S_REQ;
                end else if (!fifo_full) begin
                    wr1       = 1'b1;
                    wr2       = hold_q.two_valid;
                    buf_clear = 1'b1;
                    if (hold_q.exp[EXP_ADEL]) begin
                        next_state = S_EXC;
                    end else begin
                        pc_d       = pc_q + (pc_q[2] ? 32'd4 : 32'd8);
                        next_state = S_REQ;
                    end
                end
            end
            S_CANCEL: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (inst_data_ok) next_state = S_REQ;
            end
            S_EXC: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    next_state = S_REQ;
                end
            end
            default: next_state = S_REQ;
        endcase
    end

    // Outputs are forced low while resetn is held so nothing leaks from pre-reset state
    assign hold_out        = resetn && (state == S_HOLD);
    assign inst_req        = resetn && req;
    assign inst_addr       = resetn ? {pc_q[31:3], 3'b000} : 32'd0;
    assign write_en_1      = resetn && wr1;
    assign write_en_2      = resetn && wr2;
    assign write_inst1     = hold_out ? hold_q.inst1 : 32'd0;
    assign write_inst2     = hold_out ? hold_q.inst2 : 32'd0;
    assign write_pc1       = hold_out ? hold_q.pc : 32'd0;
    assign write_pc2       = hold_out ? hold_q.pc + 32'd4 : 32'd0;
    assign write_inst_exp1 = hold_out ? hold_q.exp : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fifo_full;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;
    logic        write_en_1, write_en_2;
    logic [31:0] write_inst1, write_inst2, write_pc1, write_pc2;
    logic [13:0] write_inst_exp1;

    int vectors = 0;
    int miscompares = 0;

    inst_fetch_unit dut (
        .clk             (clk),
        .resetn          (resetn),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fifo_full       (fifo_full),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .write_en_1      (write_en_1),
        .write_en_2      (write_en_2),
        .write_inst1     (write_inst1),
        .write_inst2     (write_inst2),
        .write_pc1       (write_pc1),
        .write_pc2       (write_pc2),
        .write_inst_exp1 (write_inst_exp1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic look;
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; fifo_full = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 64'd0;
        tick; tick;
        look;
        check("rst_req", inst_req, 0);
        check("rst_addr", inst_addr, 0);
        check("rst_we1", write_en_1, 0);
        check("rst_pc1", write_pc1, 0);

        // 1: basic aligned fetch
        tick; resetn = 1'b1; inst_addr_ok = 1'b1;
        look;
        check("t1_req", inst_req, 1);
        check("t1_addr", inst_addr, 32'hBFC0_0000);
        tick; inst_addr_ok = 1'b0;
        look;
        check("t1_wait_req", inst_req, 0);
        tick; inst_data_ok = 1'b1; inst_rdata = 64'h2222_2222_1111_1111;
        tick; inst_data_ok = 1'b0;
        look;
        check("t1_we1", write_en_1, 1);
        check("t1_we2", write_en_2, 1);
        check("t1_inst1", write_inst1, 32'h1111_1111);
        check("t1_inst2", write_inst2, 32'h2222_2222);
        check("t1_pc1", write_pc1, 32'hBFC0_0000);
        check("t1_pc2", write_pc2, 32'hBFC0_0004);
        check("t1_exp", write_inst_exp1, 0);
        check("t1_hold_req", inst_req, 0);
        tick;
        look;
        check("t1_next_req", inst_req, 1);
        check("t1_next_addr", inst_addr, 32'hBFC0_0008);
        check("t1_no_dup", write_en_1, 0);

        // 2: redirect to odd word
        redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0014;
        tick; redirect_valid = 1'b0;
        look;
        check("t2_addr", inst_addr, 32'hBFC0_0010);
        check("t2_req", inst_req, 1);
        inst_addr_ok = 1'b1;
        tick; inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 64'hAAAA_AAAA_5555_5555;
        tick; inst_data_ok = 1'b0;
        look;
        check("t2_we1", write_en_1, 1);
        check("t2_we2", write_en_2, 0);
        check("t2_inst1", write_inst1, 32'hAAAA_AAAA);
        check("t2_pc1", write_pc1, 32'hBFC0_0014);
        tick;
        look;
        check("t2_next_addr", inst_addr, 32'hBFC0_0018);

        // 3: back-pressure across data_ok
        inst_addr_ok = 1'b1;
        tick; inst_addr_ok = 1'b0; fifo_full = 1'b1; inst_data_ok = 1'b1;
        inst_rdata = 64'h4444_4444_3333_3333;
        look;
        check("t3_full_we1_dok", write_en_1, 0);
        tick; inst_data_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            look;
            check("t3_full_we1", write_en_1, 0);
            check("t3_full_req", inst_req, 0);
            tick;
        end
        fifo_full = 1'b0;
        look;
        check("t3_we1", write_en_1, 1);
        check("t3_we2", write_en_2, 1);
        check("t3_inst1", write_inst1, 32'h3333_3333);
        check("t3_inst2", write_inst2, 32'h4444_4444);
        check("t3_pc1", write_pc1, 32'hBFC0_0018);
        check("t3_pc2", write_pc2, 32'hBFC0_001C);
        tick;
        look;
        check("t3_once", write_en_1, 0);
        check("t3_next_addr", inst_addr, 32'hBFC0_0020);
        check("t3_next_req", inst_req, 1);

        // 4: redirect while waiting for data
        inst_addr_ok = 1'b1;
        tick; inst_addr_ok = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0040;
        look;
        check("t4_redir_we1", write_en_1, 0);
        tick; redirect_valid = 1'b0;
        look;
        check("t4_cancel_req", inst_req, 0);
        tick; inst_data_ok = 1'b1; inst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        look;
        check("t4_stale_we1", write_en_1, 0);
        check("t4_stale_req", inst_req, 0);
        tick; inst_data_ok = 1'b0;
        look;
        check("t4_drop_we1", write_en_1, 0);
        check("t4_req", inst_req, 1);
        check("t4_addr", inst_addr, 32'hBFC0_0040);
        inst_addr_ok = 1'b1;
        tick; inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 64'h8888_8888_7777_7777;
        tick; inst_data_ok = 1'b0;
        look;
        check("t4_we1", write_en_1, 1);
        check("t4_we2", write_en_2, 1);
        check("t4_inst1", write_inst1, 32'h7777_7777);
        check("t4_pc1", write_pc1, 32'hBFC0_0040);
        tick;
        look;
        check("t4_next_addr", inst_addr, 32'hBFC0_0048);

        // 5: misaligned redirect raises address error
        redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0102;
        tick; redirect_valid = 1'b0;
        look;
        check("t5_no_req", inst_req, 0);
        check("t5_no_we", write_en_1, 0);
        tick;
        look;
        check("t5_we1", write_en_1, 1);
        check("t5_we2", write_en_2, 0);
        check("t5_pc1", write_pc1, 32'hBFC0_0102);
        check("t5_inst1", write_inst1, 0);
        check("t5_exp", write_inst_exp1, 14'h2000);
        check("t5_hold_req", inst_req, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            look;
            check("t5_idle_req", inst_req, 0);
            check("t5_idle_we1", write_en_1, 0);
        end
        redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0200;
        tick; redirect_valid = 1'b0;
        look;
        check("t5_resume_req", inst_req, 1);
        check("t5_resume_addr", inst_addr, 32'hBFC0_0200);

        // 6: reset during WAIT with a stale response afterwards
        inst_addr_ok = 1'b1;
        tick; inst_addr_ok = 1'b0;
        tick; resetn = 1'b0;
        look;
        check("t6_rst_req", inst_req, 0);
        check("t6_rst_addr", inst_addr, 0);
        check("t6_rst_we1", write_en_1, 0);
        check("t6_rst_pc1", write_pc1, 0);
        tick; resetn = 1'b1; inst_data_ok = 1'b1; inst_rdata = 64'hFFFF_FFFF_EEEE_EEEE;
        look;
        check("t6_stale_we1", write_en_1, 0);
        check("t6_req", inst_req, 1);
        check("t6_addr", inst_addr, 32'hBFC0_0000);
        tick; inst_data_ok = 1'b0;
        look;
        check("t6_stale_we1b", write_en_1, 0);
        check("t6_addr_b", inst_addr, 32'hBFC0_0000);
        inst_addr_ok = 1'b1;
        tick; inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 64'h6666_6666_9999_9999;
        tick; inst_data_ok = 1'b0;
        look;
        check("t6_we1", write_en_1, 1);
        check("t6_inst1", write_inst1, 32'h9999_9999);
        check("t6_pc1", write_pc1, 32'hBFC0_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
